uart_line_echo: RTL and testbench
=================================

// Module: uart_line_echo
// PURPOSE
//  Line-oriented echo stage that sits on the uart_fifo pop/push interface.
//  Pops RX bytes and assembles them into a line buffer, with backspace
//  editing. On CR it replays the whole line into the TX FIFO, followed by
//  CR LF. This is the line-mode replacement for the per-byte echo path.
// PARAMETERS
//  DEPTH   64  line buffer capacity in bytes (power of two)
//  ADDR_W  6   log2(DEPTH)
// PORTS
//  clk           in   1         system clock; all logic on posedge
//  rst_n         in   1         asynchronous reset, active-low
//  rx_byte       in   8         head of RX FIFO; valid while rx_fifo_empty=0
//  rx_fifo_empty in   1         RX FIFO empty flag
//  rx_fifo_pop   out  1         1-cycle pulse; consumes rx_byte
//  tx_fifo_full  in   1         TX FIFO full flag
//  tx_byte       out  8         byte to push; valid when transmit=1
//  transmit      out  1         1-cycle push pulse into TX FIFO
//  busy          out  1         1 while replaying a line (state != ACCUM)
//  line_count    out  ADDR_W+1  bytes currently buffered (0..DEPTH)
//  overflow      out  1         sticky; a byte was dropped in the current line
// BEHAVIOUR
//  Reset (async, rst_n=0): every output is 0; count=0; rd_ptr=0; state=ACCUM.
//   Buffer contents are undefined. Reset mid-replay aborts the replay at once.
//  All outputs are registered. rx_fifo_pop and transmit never assert in two
//   consecutive cycles, so FIFO flags always have a cycle to update.
//  ACCUM: if rx_fifo_empty=0 and rx_fifo_pop=0 -> pop and handle rx_byte in the same cycle:
//   0x0D       -> state SEND, rd_ptr=0 (count=0 -> skip directly to CR)
//   0x0A       -> discard
//   0x08/0x7F  -> count>0 ? count-1 : ignore
//   other      -> count<DEPTH ? buf[count]=byte, count+1 : drop, overflow=1
//  SEND: when tx_fifo_full=0 and transmit=0: tx_byte=buf[rd_ptr], transmit=1, rd_ptr+1.
//   After the byte at rd_ptr=count-1 is sent -> CR. While full, hold with no push.
//  CR: push 0x0D (same gating as SEND) -> LF.
//  LF: push 0x0A -> ACCUM; clear count, rd_ptr and overflow in that cycle.
//  No RX pops occur in SEND/CR/LF; RX bytes stay queued in the RX FIFO.
//  Pop and push never coincide within a cycle.
//  count=DEPTH exactly: the line is replayed in full; later bytes are dropped (no wrap).
//  busy=1 in SEND, CR and LF. line_count tracks count live.
// CONFIGURATION
//  UART_LINE_ECHO_LOCAL_EN defined: local echo while typing, in ACCUM:
//   - A stored byte is pushed once to TX after its pop (gated on tx_fifo_full).
//   - An effective backspace pushes 0x08 0x20 0x08.
//   - Dropped bytes, ignored backspaces and 0x0A push nothing.
//   - No further RX pop until the echo completes.
//   - The CR replay is unchanged.
//  Undefined: ACCUM never asserts transmit; TX carries only the replay.
// TESTING
//  1. RX "AB\r" -> TX 41 42 0D 0A; line_count 0->1->2->0; busy high during replay.
//  2. RX "ABX\x08C\r" -> TX 41 42 43 0D 0A. Also "\x08\r" on empty line -> TX 0D 0A only.
//  3. RX 70 x 0x55 then "\r" (DEPTH=64) -> 64 x 55, then 0D 0A.
//     overflow=1 from the 65th byte, 0 after LF.
//  4. tx_fifo_full=1 for 20 cycles mid-replay -> no transmit while full; order intact,
//     nothing lost. RX queued during replay is popped only after LF.
//  5. rst_n low during SEND -> all outputs 0 within the same cycle; next "Z\r" -> 5A 0D 0A.
//  6. With UART_LINE_ECHO_LOCAL_EN, RX "a\x08b\r" -> 61 08 20 08 62 62 0D 0A.

Source files
------------

// File: rtl/uart_line_echo_if.sv
// Pop/push handshake between uart_line_echo and the RX/TX FIFOs, plus status.
// master = echo stage, slave = FIFO/status side.
interface uart_line_echo_if #(
    parameter int ADDR_W = 6
);
    logic [7:0]      rx_byte;
    logic            rx_fifo_empty;
    logic            rx_fifo_pop;
    logic            tx_fifo_full;
    logic [7:0]      tx_byte;
    logic            transmit;
    logic            busy;
    logic [ADDR_W:0] line_count;
    logic            overflow;

    modport master (
        input  rx_byte, rx_fifo_empty, tx_fifo_full,
        output rx_fifo_pop, tx_byte, transmit, busy, line_count, overflow
    );

    modport slave (
        output rx_byte, rx_fifo_empty, tx_fifo_full,
        input  rx_fifo_pop, tx_byte, transmit, busy, line_count, overflow
    );
endinterface

// File: rtl/uart_line_echo.sv
// Line-mode echo: buffers RX bytes with backspace editing, replays the line plus CR LF on CR.
// Optional UART_LINE_ECHO_LOCAL_EN: echo each edit to TX while the line is being typed.
module uart_line_echo #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_line_echo_if.master bus
);
    localparam logic [7:0]      CH_BS   = 8'h08;
    localparam logic [7:0]      CH_LF   = 8'h0A;
    localparam logic [7:0]      CH_CR   = 8'h0D;
    localparam logic [7:0]      CH_DEL  = 8'h7F;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
`ifdef UART_LINE_ECHO_LOCAL_EN
    localparam logic [7:0]      CH_SP   = 8'h20;
`endif

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SEND  = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;

    state_t          state_r;
    logic [ADDR_W:0] count_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [7:0]      line_mem_r [DEPTH];
    logic            pop_r;
    logic            transmit_r;
    logic            busy_r;
    logic            overflow_r;
    logic [7:0]      tx_byte_r;

`ifdef UART_LINE_ECHO_LOCAL_EN
    logic [1:0]      echo_left_r;
    logic            echo_bs_r;
    logic [7:0]      echo_byte_r;
`endif

    logic echo_idle_s;
    logic accept_s;
    logic is_cr_s;
    logic is_lf_s;
    logic is_bs_s;
    logic has_room_s;
    logic store_s;
    logic can_push_s;
    logic last_s;

    // Classify the RX head byte and decide whether it is consumed this cycle
    always_comb begin
`ifdef UART_LINE_ECHO_LOCAL_EN
        echo_idle_s = (echo_left_r == 2'd0);
`else
        echo_idle_s = 1'b1;
`endif
        accept_s   = (state_r == ACCUM) && !bus.rx_fifo_empty && !pop_r && echo_idle_s;
        is_cr_s    = (bus.rx_byte == CH_CR);
        is_lf_s    = (bus.rx_byte == CH_LF);
        is_bs_s    = (bus.rx_byte == CH_BS) || (bus.rx_byte == CH_DEL);
        has_room_s = (count_r < DEPTH_C);
        store_s    = accept_s && !is_cr_s && !is_lf_s && !is_bs_s && has_room_s;
        can_push_s = !bus.tx_fifo_full && !transmit_r;
        last_s     = (({1'b0, rd_ptr_r} + ONE_C) == count_r);
    end

    // Line storage; contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (store_s) begin
            line_mem_r[count_r[ADDR_W-1:0]] <= bus.rx_byte;
        end
    end

    // Control FSM: accumulate, then replay line, CR, LF with one-cycle-gap pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            count_r     <= '0;
            rd_ptr_r    <= '0;
            pop_r       <= 1'b0;
            transmit_r  <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            tx_byte_r   <= 8'h00;
`ifdef UART_LINE_ECHO_LOCAL_EN
            echo_left_r <= 2'd0;
            echo_bs_r   <= 1'b0;
            echo_byte_r <= 8'h00;
`endif
        end else begin
            pop_r      <= 1'b0;
            transmit_r <= 1'b0;
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        pop_r <= 1'b1;
                        if (is_cr_s) begin
                            rd_ptr_r <= '0;
                            busy_r   <= 1'b1;
                            state_r  <= (count_r == '0) ? CR : SEND;
                        end else if (is_lf_s) begin
                            count_r <= count_r;
                        end else if (is_bs_s) begin
                            if (count_r != '0) begin
                                count_r <= count_r - ONE_C;
`ifdef UART_LINE_ECHO_LOCAL_EN
                                echo_left_r <= 2'd3;
                                echo_bs_r   <= 1'b1;
`endif
                            end
                        end else if (has_room_s) begin
                            count_r <= count_r + ONE_C;
`ifdef UART_LINE_ECHO_LOCAL_EN
                            echo_left_r <= 2'd1;
                            echo_bs_r   <= 1'b0;
                            echo_byte_r <= bus.rx_byte;
`endif
                        end else begin
                            overflow_r <= 1'b1;
                        end
                    end
`ifdef UART_LINE_ECHO_LOCAL_EN
                    // Erase sequence is BS SP BS; the middle slot carries the space
                    else if (!echo_idle_s && can_push_s) begin
                        transmit_r  <= 1'b1;
                        tx_byte_r   <= echo_bs_r ? ((echo_left_r == 2'd2) ? CH_SP : CH_BS)
                                                 : echo_byte_r;
                        echo_left_r <= echo_left_r - 2'd1;
                    end
`endif
                end
                SEND: begin
                    if (can_push_s) begin
                        transmit_r <= 1'b1;
                        tx_byte_r  <= line_mem_r[rd_ptr_r];
                        rd_ptr_r   <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (last_s) begin
                            state_r <= CR;
                        end
                    end
                end
                CR: begin
                    if (can_push_s) begin
                        transmit_r <= 1'b1;
                        tx_byte_r  <= CH_CR;
                        state_r    <= LF;
                    end
                end
                LF: begin
                    if (can_push_s) begin
                        transmit_r <= 1'b1;
                        tx_byte_r  <= CH_LF;
                        state_r    <= ACCUM;
                        busy_r     <= 1'b0;
                        count_r    <= '0;
                        rd_ptr_r   <= '0;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_fifo_pop = pop_r;
    assign bus.transmit    = transmit_r;
    assign bus.tx_byte     = tx_byte_r;
    assign bus.busy        = busy_r;
    assign bus.line_count  = count_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo: directed vector table, corner sequences,
// and random lines checked against a queue-based line-editor model.
module tb_uart_line_echo;
`ifdef UART_LINE_ECHO_LOCAL_EN
    localparam bit LOCAL = 1'b1;
`else
    localparam bit LOCAL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    uart_line_echo_if #(.ADDR_W(6)) bus ();

    uart_line_echo #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;
    int proto_errs;

    logic [7:0] rx_q   [$];
    logic [7:0] tx_got [$];
    logic [7:0] exp_tx [$];
    logic [7:0] line_q [$];
    bit         m_ovf;

    bit  tx_full, prev_tx, prev_pop, prev_busy, rand_full, busy_seen;
    int  full_hold;
    int  lc_trace [$];
    int  last_lc;

    typedef struct {
        logic [127:0] rx;
        int           rx_len;
        logic [255:0] tx_d;
        int           tx_d_len;
        logic [255:0] tx_l;
        int           tx_l_len;
        int           lc;
        bit           has_cr;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Line-editor reference: a queue for the line, output bytes appended to exp_tx
    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'h0D) begin
            foreach (line_q[i]) exp_tx.push_back(line_q[i]);
            exp_tx.push_back(8'h0D);
            exp_tx.push_back(8'h0A);
            line_q.delete();
            m_ovf = 1'b0;
        end else if (b == 8'h0A) begin
            m_ovf = m_ovf;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) begin
                void'(line_q.pop_back());
                if (LOCAL) begin
                    exp_tx.push_back(8'h08);
                    exp_tx.push_back(8'h20);
                    exp_tx.push_back(8'h08);
                end
            end
        end else if (line_q.size() < 64) begin
            line_q.push_back(b);
            if (LOCAL) exp_tx.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endfunction

    task automatic drive_rx();
        bus.rx_fifo_empty = (rx_q.size() == 0);
        bus.rx_byte       = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic send(input logic [7:0] b, input bit use_model);
        rx_q.push_back(b);
        if (use_model) model_byte(b);
        drive_rx();
    endtask

    // One clock: observe outputs at negedge, model both FIFOs, update flow control
    task automatic cycle();
        @(negedge clk);
        if (bus.transmit === 1'b1) begin
            tx_got.push_back(bus.tx_byte);
            if (tx_full || prev_tx) proto_errs++;
        end
        if (bus.rx_fifo_pop === 1'b1) begin
            if (rx_q.size() == 0) proto_errs++;
            else void'(rx_q.pop_front());
            if (prev_pop || prev_busy || bus.transmit === 1'b1) proto_errs++;
        end
        if (bus.busy === 1'b1) busy_seen = 1'b1;
        if (int'(bus.line_count) != last_lc) begin
            last_lc = int'(bus.line_count);
            lc_trace.push_back(last_lc);
        end
        prev_tx   = (bus.transmit === 1'b1);
        prev_pop  = (bus.rx_fifo_pop === 1'b1);
        prev_busy = (bus.busy === 1'b1);
        if (full_hold > 0) begin
            tx_full = 1'b1;
            full_hold--;
        end else if (rand_full && $urandom_range(0, 9) == 0) begin
            tx_full   = 1'b1;
            full_hold = $urandom_range(0, 5);
        end else begin
            tx_full = 1'b0;
        end
        bus.tx_fifo_full = tx_full;
        drive_rx();
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (n < 5000 && (rx_q.size() != 0 || tx_got.size() < exp_tx.size() || bus.busy === 1'b1)) begin
            cycle();
            n++;
        end
        repeat (6) cycle();
        chk({nm, "_done"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic cmp_stream(input string nm);
        int bad = -1;
        checks++;
        for (int i = 0; i < tx_got.size() && i < exp_tx.size(); i++) begin
            if (bad < 0 && tx_got[i] !== exp_tx[i]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s byte %0d actual=%02h required=%02h", nm, bad, tx_got[bad], exp_tx[bad]);
        end else if (tx_got.size() != exp_tx.size()) begin
            errors++;
            $display("FAIL %s length actual=%0d required=%0d", nm, tx_got.size(), exp_tx.size());
        end
        tx_got.delete();
        exp_tx.delete();
    endtask

    function automatic logic [7:0] byte_at(input logic [255:0] v, input int len, input int i);
        return v[8*(len-1-i) +: 8];
    endfunction

    initial begin
        int n;
        int stall_at;
        logic [255:0] tx_v;
        int tx_len;
        checks = 0; errors = 0; proto_errs = 0;
        clk = 1'b0; rst_n = 1'b0;
        bus.rx_fifo_empty = 1'b1; bus.rx_byte = 8'h00; bus.tx_fifo_full = 1'b0;
        tx_full = 0; prev_tx = 0; prev_pop = 0; prev_busy = 0; rand_full = 0;
        full_hold = 0; last_lc = 0; m_ovf = 0; busy_seen = 0;

        tbl[0] = '{128'({8'h41,8'h42,8'h0D}), 3, 256'({8'h41,8'h42,8'h0D,8'h0A}), 4,
                   256'({8'h41,8'h42,8'h41,8'h42,8'h0D,8'h0A}), 6, 0, 1'b1};
        tbl[1] = '{128'({8'h41,8'h42,8'h58,8'h08,8'h43,8'h0D}), 6,
                   256'({8'h41,8'h42,8'h43,8'h0D,8'h0A}), 5,
                   256'({8'h41,8'h42,8'h58,8'h08,8'h20,8'h08,8'h43,8'h41,8'h42,8'h43,8'h0D,8'h0A}), 12, 0, 1'b1};
        tbl[2] = '{128'({8'h08,8'h0D}), 2, 256'({8'h0D,8'h0A}), 2, 256'({8'h0D,8'h0A}), 2, 0, 1'b1};
        tbl[3] = '{128'({8'h0A,8'h0D}), 2, 256'({8'h0D,8'h0A}), 2, 256'({8'h0D,8'h0A}), 2, 0, 1'b1};
        tbl[4] = '{128'({8'h61,8'h08,8'h62,8'h0D}), 4, 256'({8'h62,8'h0D,8'h0A}), 3,
                   256'({8'h61,8'h08,8'h20,8'h08,8'h62,8'h62,8'h0D,8'h0A}), 8, 0, 1'b1};
        tbl[5] = '{128'({8'h48,8'h69}), 2, 256'h0, 0, 256'({8'h48,8'h69}), 2, 2, 1'b0};
        tbl[6] = '{128'({8'h7F,8'h0D}), 2, 256'({8'h48,8'h0D,8'h0A}), 3,
                   256'({8'h08,8'h20,8'h08,8'h48,8'h0D,8'h0A}), 6, 0, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({bus.rx_fifo_pop, bus.transmit, bus.busy, bus.overflow, bus.line_count, bus.tx_byte}), 32'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            lc_trace.delete();
            busy_seen = 1'b0;
            tx_v   = LOCAL ? tbl[i].tx_l : tbl[i].tx_d;
            tx_len = LOCAL ? tbl[i].tx_l_len : tbl[i].tx_d_len;
            for (int j = 0; j < tx_len; j++) exp_tx.push_back(byte_at(tx_v, tx_len, j));
            for (int j = 0; j < tbl[i].rx_len; j++) send(tbl[i].rx[8*(tbl[i].rx_len-1-j) +: 8], 1'b0);
            drain($sformatf("vec%0d", i));
            cmp_stream($sformatf("vec%0d_tx", i));
            chk($sformatf("vec%0d_line_count", i), 32'(bus.line_count), 32'(tbl[i].lc));
            chk($sformatf("vec%0d_busy_seen", i), 32'(busy_seen), 32'(tbl[i].has_cr));
            if (i == 0) chk("vec0_lc_trace", 32'({lc_trace.size() == 3 ? lc_trace[0] : -1, lc_trace.size() == 3 ? lc_trace[1] : -1, lc_trace.size() == 3 ? lc_trace[2] : -1} == {32'd1, 32'd2, 32'd0}), 32'd1);
        end

        // Overflow at exactly DEPTH, then dropped bytes, then full replay
        for (int j = 0; j < 64; j++) send(8'h55, 1'b1);
        drain("fill64");
        chk("fill64_count", 32'(bus.line_count), 32'd64);
        chk("fill64_ovf", 32'(bus.overflow), 32'd0);
        send(8'h55, 1'b1);
        drain("byte65");
        chk("byte65_ovf", 32'(bus.overflow), 32'd1);
        chk("byte65_count", 32'(bus.line_count), 32'd64);
        for (int j = 0; j < 5; j++) send(8'h55, 1'b1);
        send(8'h0D, 1'b1);
        drain("full_line");
        cmp_stream("full_line_tx");
        chk("full_line_ovf_clear", 32'(bus.overflow), 32'd0);
        chk("full_line_count", 32'(bus.line_count), 32'd0);

        // TX full for 20 cycles mid-replay, with RX queued behind the CR
        for (int j = 0; j < 10; j++) send(8'h30 + 8'(j), 1'b1);
        stall_at = exp_tx.size() + 3;
        send(8'h0D, 1'b1);
        send(8'h51, 1'b1);
        n = 0;
        while (n < 2000 && tx_got.size() < stall_at) begin cycle(); n++; end
        chk("stall_reach", 32'(n < 2000), 32'd1);
        full_hold = 19; tx_full = 1'b1; bus.tx_fifo_full = 1'b1;
        repeat (20) cycle();
        chk("stall_no_push", 32'(tx_got.size()), 32'(stall_at));
        chk("stall_rx_held", 32'(rx_q.size()), 32'd1);
        drain("stall");
        cmp_stream("stall_tx");
        chk("stall_q_buffered", 32'(bus.line_count), 32'd1);
        send(8'h0D, 1'b1);
        drain("stall_q");
        cmp_stream("stall_q_tx");

        // Asynchronous reset in the middle of a replay
        for (int j = 0; j < 8; j++) send(8'h61 + 8'(j), 1'b0);
        send(8'h0D, 1'b0);
        n = 0;
        while (n < 500 && !(bus.busy === 1'b1 && bus.transmit === 1'b1)) begin cycle(); n++; end
        chk("rst_reach_send", 32'(n < 500), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_outputs", 32'({bus.rx_fifo_pop, bus.transmit, bus.busy, bus.overflow, bus.line_count, bus.tx_byte}), 32'd0);
        rx_q.delete(); tx_got.delete(); exp_tx.delete(); line_q.delete(); m_ovf = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        tx_got.delete();
        send(8'h5A, 1'b1);
        send(8'h0D, 1'b1);
        drain("after_rst");
        cmp_stream("after_rst_tx");

        // Random lines with random TX back-pressure
        rand_full = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 80);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 9))
                    0:       send(8'h08, 1'b1);
                    1:       send(8'h7F, 1'b1);
                    2:       send(8'h0A, 1'b1);
                    default: send(8'h41 + 8'($urandom_range(0, 25)), 1'b1);
                endcase
            end
            drain($sformatf("rnd%0d_pre", k));
            chk($sformatf("rnd%0d_count", k), 32'(bus.line_count), 32'(line_q.size()));
            chk($sformatf("rnd%0d_ovf", k), 32'(bus.overflow), 32'(m_ovf));
            send(8'h0D, 1'b1);
            drain($sformatf("rnd%0d", k));
            cmp_stream($sformatf("rnd%0d_tx", k));
        end
        rand_full = 1'b0;

        chk("protocol", 32'(proto_errs), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
